fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the fetch stage: drives PC write-enable, PC mux select, IF/ID write-enable and IF/ID flush.
- Handles a variable-latency instruction-memory handshake, hazard stalls, branch redirects and halt.
- Sits between the hazard/branch logic (MEM stage) and the fetch datapath; the PC register, PC+4 adder and PC mux stay in the fetch datapath.

Parameters:
WORD, 64, PC/target width in bits (matches `WORD)
BOOT_CYCLES, 2, cycles held in BOOT after reset release before the first request (covers the imem clock delay)
MAX_WAIT, 15, cycles without imem_ack before the timeout error; counter width is $clog2(MAX_WAIT+1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = in reset
branch_taken  in  1  one-cycle pulse, branch resolved taken
branch_target  in  WORD  target, valid with branch_taken
stall_req  in  1  level, hazard unit requests a fetch freeze
halt_req  in  1  level, stop fetching
imem_ack  in  1  instruction word valid this cycle
imem_req  out  1  request fetch at the current PC
pc_write  out  1  PC register load enable
pc_src  out  1  PC mux select: 0 = PC+4, 1 = redirect_target
redirect_target  out  WORD  registered pending branch target
if_id_write  out  1  latch the fetched instruction into IF/ID
if_flush  out  1  write a bubble into IF/ID
halted  out  1  FSM is in HALT
timeout_err  out  1  FSM is in ERR

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - state=BOOT and boot counter=0.
  - pending_valid=0, redirect_target=0 and wait counter=0.
  - All 1-bit outputs are 0.
- Outputs are decoded combinationally from the registered state, pending registers, imem_ack, stall_req and halt_req. There are no combinational paths from branch_* to outputs.
- State BOOT:
  - Boot counter increments each cycle.
  - At BOOT_CYCLES-1, go to REQ.
- State REQ:
  - imem_req=1.
  - Wait counter increments each cycle while imem_ack=0 and clears on ack.
  - If the counter reaches MAX_WAIT, go to ERR.
- On imem_ack in REQ (the "advance point"), in priority order:
  1. pending_valid=1: pc_write=1, pc_src=1, if_flush=1, if_id_write=0. Clear pending_valid. Stay in REQ. The branch overrides stall and halt.
  2. halt_req=1: go to HALT. No PC write and no IF/ID write.
  3. stall_req=1: go to STALL. pc_write=0 and if_id_write=0. The acked word is dropped and refetched later.
  4. Otherwise: pc_write=1, pc_src=0, if_id_write=1. Stay in REQ.
- State STALL:
  - imem_req=0; all enables 0.
  - Go to REQ in the first cycle stall_req=0.
  - If pending_valid=1, go to REQ regardless of stall_req, because the redirect flushes the stall source.
  - halt_req in STALL goes to HALT.
- Branch capture:
  - branch_taken=1 with pending_valid=0 loads redirect_target and sets pending_valid on the next edge. This can happen in any state except HALT and ERR.
  - branch_taken while pending_valid=1 is ignored; the older branch wins and the younger one is wrong-path.
  - branch_taken on the same cycle as an advance that consumes the pending entry is captured as the new pending entry.
- HALT: halted=1; all enables 0; imem_req=0. Exited only by reset.
- ERR: timeout_err=1; all enables 0. Exited only by reset.
- Reset asserted mid-transaction: the ack is abandoned. After release, BOOT is re-entered and PC reload is the datapath's job.
- Invariants:
  - pc_write and if_id_write are never 1 unless imem_ack=1 in REQ.
  - if_flush and if_id_write are never both 1.

Decomposition:
- Shared package/header (definitions.vh): state encoding localparams BOOT=0, REQ=1, STALL=2, HALT=3, ERR=4 (3 bits), and the existing `WORD.
- One sub-module, fetch_branch_latch: holds pending_valid and redirect_target, with capture and consume inputs. Everything else stays in fetch_ctrl.

Test Plan:
1. Reset release, BOOT_CYCLES=2, imem_ack tied 1 -> imem_req rises on cycle 2; pc_write=1, if_id_write=1 every cycle from then on; pc_src=0.
2. branch_taken pulse with target 64'h100 while waiting (ack=0 for 3 cycles) -> redirect_target=64'h100 next cycle; on the ack: pc_src=1, pc_write=1, if_flush=1, if_id_write=0; pending cleared.
3. stall_req=1 for 4 cycles with ack=1 -> STALL entered, enables 0 for 4 cycles; REQ on the cycle after stall_req falls; the next ack advances the PC.
4. Two branch pulses (0x200, then 0x300) 2 cycles apart before any ack -> redirect to 0x200 only; 0x300 ignored.
5. imem_ack held 0 for 15 cycles after BOOT -> timeout_err=1 on cycle 15, imem_req=0, stuck until reset=0.
6. halt_req=1 during STALL with pending_valid=0 -> halted=1 next cycle; branch_taken afterwards has no effect; asynchronous reset mid-HALT returns all outputs to 0 immediately.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage controller: default sizing and the
// controller state encoding.
package fetch_ctrl_pkg;

  localparam int FETCH_WORD        = 64;
  localparam int FETCH_BOOT_CYCLES = 2;
  localparam int FETCH_MAX_WAIT    = 15;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_STALL = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_e;

  // A younger branch may only be captured while the fetch stage is alive.
  function automatic logic capture_allowed(input fetch_state_e s);
    return (s != ST_HALT) && (s != ST_ERR);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch controller and the surrounding hazard,
// branch and instruction-memory logic. master = controller side.
interface fetch_ctrl_if import fetch_ctrl_pkg::*; #(
  parameter int WORD = FETCH_WORD
);

  logic            branch_taken;
  logic [WORD-1:0] branch_target;
  logic            stall_req;
  logic            halt_req;
  logic            imem_ack;
  logic            imem_req;
  logic            pc_write;
  logic            pc_src;
  logic [WORD-1:0] redirect_target;
  logic            if_id_write;
  logic            if_flush;
  logic            halted;
  logic            timeout_err;

  modport master (
    input  branch_taken, branch_target, stall_req, halt_req, imem_ack,
    output imem_req, pc_write, pc_src, redirect_target,
           if_id_write, if_flush, halted, timeout_err
  );

  modport slave (
    output branch_taken, branch_target, stall_req, halt_req, imem_ack,
    input  imem_req, pc_write, pc_src, redirect_target,
           if_id_write, if_flush, halted, timeout_err
  );

endinterface

// File: rtl/fetch_branch_latch.sv
// Single-entry holding register for a resolved taken branch. The oldest
// branch wins: the owner gates capture so a new target only lands when the
// slot is empty or is being consumed in the same cycle.
module fetch_branch_latch #(
  parameter int WORD = fetch_ctrl_pkg::FETCH_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  input  logic            consume,
  input  logic [WORD-1:0] target_in,
  output logic            pending_valid,
  output logic [WORD-1:0] redirect_target
);

  // Capture takes precedence so a back-to-back branch refills the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_valid   <= 1'b0;
      redirect_target <= '0;
    end else if (capture) begin
      pending_valid   <= 1'b1;
      redirect_target <= target_in;
    end else if (consume) begin
      pending_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: paces instruction-memory requests and drives the
// PC / IF-ID enables around stalls, branch redirects, halt and timeout.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BOOT  | post-reset settle, waits for the imem clock to come up
//   REQ   | fetch request outstanding, acts on imem_ack
//   STALL | hazard freeze, no request, waits for stall_req to drop
//   HALT  | fetching stopped, left only by reset
//   ERR   | imem never answered, left only by reset
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter int WORD        = FETCH_WORD,
  parameter int BOOT_CYCLES = FETCH_BOOT_CYCLES,
  parameter int MAX_WAIT    = FETCH_MAX_WAIT
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  fetch_state_e    state, state_next;
  logic [BW-1:0]   boot_cnt, boot_cnt_next;
  logic [WW-1:0]   wait_cnt, wait_cnt_next;
  logic            pending_valid;
  logic [WORD-1:0] redirect_target;
  logic            advance, consume, capture;

  logic imem_req, pc_write, pc_src, if_id_write, if_flush, halted, timeout_err;

  assign advance = (state == ST_REQ) && bus.imem_ack;
  assign consume = advance && pending_valid;
  assign capture = bus.branch_taken && capture_allowed(state) &&
                   (!pending_valid || consume);

  fetch_branch_latch #(.WORD(WORD)) u_branch_latch (
    .clk             (clk),
    .reset           (reset),
    .capture         (capture),
    .consume         (consume),
    .target_in       (bus.branch_target),
    .pending_valid   (pending_valid),
    .redirect_target (redirect_target)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_BOOT;
      boot_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      boot_cnt <= boot_cnt_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state and output decode; a pending redirect beats halt and stall.
  always_comb begin
    state_next    = state;
    boot_cnt_next = boot_cnt;
    wait_cnt_next = '0;
    imem_req      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    if_id_write   = 1'b0;
    if_flush      = 1'b0;
    halted        = 1'b0;
    timeout_err   = 1'b0;
    case (state)
      ST_BOOT: begin
        boot_cnt_next = boot_cnt + 1'b1;
        if (boot_cnt == BOOT_LAST) begin
          state_next    = ST_REQ;
          boot_cnt_next = '0;
        end
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          if (pending_valid) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            if_flush = 1'b1;
          end else if (bus.halt_req) begin
            state_next = ST_HALT;
          end else if (bus.stall_req) begin
            state_next = ST_STALL;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_next = ST_ERR;
          end
        end
      end
      ST_STALL: begin
        if (pending_valid) begin
          state_next = ST_REQ;
        end else if (bus.halt_req) begin
          state_next = ST_HALT;
        end else if (!bus.stall_req) begin
          state_next = ST_REQ;
        end
      end
      ST_HALT: halted = 1'b1;
      ST_ERR:  timeout_err = 1'b1;
      default: state_next = ST_BOOT;
    endcase
  end

  assign bus.imem_req        = imem_req;
  assign bus.pc_write        = pc_write;
  assign bus.pc_src          = pc_src;
  assign bus.redirect_target = redirect_target;
  assign bus.if_id_write     = if_id_write;
  assign bus.if_flush        = if_flush;
  assign bus.halted          = halted;
  assign bus.timeout_err     = timeout_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the fetch stage.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int W     = 64;
  localparam int BOOTC = 2;
  localparam int MAXW  = 15;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  fetch_ctrl_if #(.WORD(W)) bus ();

  fetch_ctrl #(.WORD(W), .BOOT_CYCLES(BOOTC), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the fetch stage is doing, not how it is encoded.
  int           m_boot_left;
  bit           m_req, m_frozen, m_stopped, m_dead;
  int           m_misses;
  bit           m_pend;
  logic [W-1:0] m_tgt;

  function automatic void model_reset();
    m_boot_left = BOOTC;
    m_req = 0; m_frozen = 0; m_stopped = 0; m_dead = 0;
    m_misses = 0; m_pend = 0; m_tgt = '0;
  endfunction

  function automatic logic [70:0] exp_out();
    logic req, pw, ps, iw, fl;
    req = 0; pw = 0; ps = 0; iw = 0; fl = 0;
    if (m_req) begin
      req = 1;
      if (bus.imem_ack) begin
        if (m_pend) begin
          pw = 1; ps = 1; fl = 1;
        end else if (!bus.halt_req && !bus.stall_req) begin
          pw = 1; iw = 1;
        end
      end
    end
    return {req, pw, ps, iw, fl, logic'(m_stopped), logic'(m_dead), m_tgt};
  endfunction

  function automatic logic [70:0] obs();
    return {bus.imem_req, bus.pc_write, bus.pc_src, bus.if_id_write,
            bus.if_flush, bus.halted, bus.timeout_err, bus.redirect_target};
  endfunction

  function automatic void model_step();
    bit consume, old_pend;
    old_pend = m_pend;
    consume  = m_req && bus.imem_ack && m_pend;
    if (!m_stopped && !m_dead && bus.branch_taken && (!m_pend || consume)) begin
      m_pend = 1;
      m_tgt  = bus.branch_target;
    end else if (consume) begin
      m_pend = 0;
    end
    if (m_boot_left > 0) begin
      m_boot_left--;
      if (m_boot_left == 0) m_req = 1;
    end else if (m_req) begin
      if (bus.imem_ack) begin
        m_misses = 0;
        if (!old_pend) begin
          if (bus.halt_req) begin
            m_req = 0; m_stopped = 1;
          end else if (bus.stall_req) begin
            m_req = 0; m_frozen = 1;
          end
        end
      end else begin
        m_misses++;
        if (m_misses == MAXW) begin
          m_req = 0; m_dead = 1;
        end
      end
    end else if (m_frozen) begin
      if (old_pend) begin
        m_frozen = 0; m_req = 1;
      end else if (bus.halt_req) begin
        m_frozen = 0; m_stopped = 1;
      end else if (!bus.stall_req) begin
        m_frozen = 0; m_req = 1;
      end
    end
  endfunction

  task automatic set_in(input logic bt, input logic [W-1:0] tgt, input logic st,
                        input logic hr, input logic ack);
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.stall_req     = st;
    bus.halt_req      = hr;
    bus.imem_ack      = ack;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Enter reset from just after an edge and release one edge later, so the
  // following clock period is boot cycle 0.
  task automatic do_reset();
    set_in(0, '0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_in(0, '0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    #2;
    if (obs() !== 71'd0) begin
      errs++;
      $display("FAIL reset_outputs got=%h exp=%h", obs(), 71'd0);
    end
    vecs++;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_boot();
    logic [3:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      set_in(0, '0, 0, 0, 1);
      @(negedge clk);
      if (obs() !== exp_out()) begin
        errs++;
        $display("FAIL boot_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
      vecs++;
      got = {bus.imem_req, bus.pc_write, bus.if_id_write, bus.pc_src};
      exp = (i >= BOOTC) ? 4'b1110 : 4'b0000;
      if (got !== exp) begin
        errs++;
        $display("FAIL boot_req_pcw_ifw_src cyc=%0d got=%b exp=%b", i, got, exp);
      end
      vecs++;
      advance();
    end
  endtask

  task automatic test_branch_redirect();
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_in(i == 2, (i == 2) ? 64'h100 : 64'h0, 0, 0, i >= 5);
      @(negedge clk);
      if (obs() !== exp_out()) begin
        errs++;
        $display("FAIL branch_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
      vecs++;
      got = {bus.pc_src, bus.pc_write, bus.if_flush, bus.if_id_write};
      if (i == 3 && bus.redirect_target !== 64'h100) begin
        errs++;
        $display("FAIL branch_target got=%h exp=%h", bus.redirect_target, 64'h100);
      end
      if (i == 5 && got !== 4'b1110) begin
        errs++;
        $display("FAIL branch_redirect got=%b exp=%b", got, 4'b1110);
      end
      if (i == 6 && got !== 4'b0101) begin
        errs++;
        $display("FAIL branch_after_consume got=%b exp=%b", got, 4'b0101);
      end
      if (i == 3 || i == 5 || i == 6) vecs++;
      advance();
    end
  endtask

  task automatic test_stall();
    logic [2:0] got, exp;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(0, '0, (i >= 3 && i <= 6), 0, 1);
      @(negedge clk);
      if (obs() !== exp_out()) begin
        errs++;
        $display("FAIL stall_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
      vecs++;
      got = {bus.imem_req, bus.pc_write, bus.if_id_write};
      if (i == 3)                exp = 3'b100;
      else if (i >= 4 && i <= 7) exp = 3'b000;
      else if (i >= 2)           exp = 3'b111;
      else                       exp = 3'b000;
      if (got !== exp) begin
        errs++;
        $display("FAIL stall_req_pcw_ifw cyc=%0d got=%b exp=%b", i, got, exp);
      end
      vecs++;
      advance();
    end
  endtask

  task automatic test_double_branch();
    logic [W-1:0] t;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      t = (i == 2) ? 64'h200 : ((i == 4) ? 64'h300 : 64'h0);
      set_in(i == 2 || i == 4, t, 0, 0, i >= 6);
      @(negedge clk);
      if (obs() !== exp_out()) begin
        errs++;
        $display("FAIL dbl_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
      vecs++;
      if (i >= 3 && bus.redirect_target !== 64'h200) begin
        errs++;
        $display("FAIL dbl_target cyc=%0d got=%h exp=%h", i, bus.redirect_target, 64'h200);
      end
      if (i >= 3) vecs++;
      if (i >= 6 && bus.pc_src !== (i == 6)) begin
        errs++;
        $display("FAIL dbl_pc_src cyc=%0d got=%b exp=%b", i, bus.pc_src, (i == 6));
      end
      if (i >= 6) vecs++;
      advance();
    end
  endtask

  task automatic test_timeout();
    logic [1:0] got, exp;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      set_in(0, '0, 0, 0, i >= 20);
      @(negedge clk);
      if (obs() !== exp_out()) begin
        errs++;
        $display("FAIL timeout_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
      vecs++;
      got = {bus.timeout_err, bus.imem_req};
      exp = {i >= BOOTC + MAXW, i >= BOOTC && i < BOOTC + MAXW};
      if (got !== exp) begin
        errs++;
        $display("FAIL timeout_err_req cyc=%0d got=%b exp=%b", i, got, exp);
      end
      vecs++;
      advance();
    end
    reset = 1'b0;
    model_reset();
    #1;
    if (bus.timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL timeout_reset got=%b exp=0", bus.timeout_err);
    end
    vecs++;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_in(i == 7, 64'hdead, i == 3 || i == 4, i == 4, 1);
      @(negedge clk);
      if (obs() !== exp_out()) begin
        errs++;
        $display("FAIL halt_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
      vecs++;
      if (i >= 5 && (bus.halted !== 1'b1 || bus.redirect_target !== 64'h0 ||
                     bus.imem_req !== 1'b0)) begin
        errs++;
        $display("FAIL halt_hold cyc=%0d got=%b/%h/%b exp=1/0/0", i,
                 bus.halted, bus.redirect_target, bus.imem_req);
      end
      if (i >= 5) vecs++;
      advance();
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    if (obs() !== 71'd0) begin
      errs++;
      $display("FAIL halt_async_reset got=%h exp=%h", obs(), 71'd0);
    end
    vecs++;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic st_lvl;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      st_lvl = 0;
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(5) == 0) st_lvl = ~st_lvl;
        set_in($urandom_range(7) == 0, {$urandom(), $urandom()}, st_lvl,
               $urandom_range(249) == 0, $urandom_range(3) != 0);
        @(negedge clk);
        if (obs() !== exp_out()) begin
          errs++;
          $display("FAIL random_model run=%0d cyc=%0d got=%h exp=%h", r, i, obs(), exp_out());
        end
        vecs++;
        advance();
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_boot();
    test_branch_redirect();
    test_stall();
    test_double_branch();
    test_timeout();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

endmodule
